// File: rtl/pc_fetch.sv
// PC register, EPC capture and instruction-fetch sequencer for the multicycle MIPS datapath.
// Define PC_FETCH_TIMEOUT_EN to abort a stalled fetch with bus_err after TIMEOUT wait cycles.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        cond_true,
  input  logic        epc_write,
  input  logic        fetch_start,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] ir_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        mem_rd_q, busy_q, instr_valid_q;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_d;

`ifdef PC_FETCH_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = pc_in;
    end else if (pc_write_cond && cond_true) begin
      pc_d = pc_in;
    end
    epc_d = epc_write ? fetch_addr_q : epc_q;
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    fetch_addr_d = fetch_addr_q;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
    wcnt_d       = wcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fetch_start) begin
          if (pc_q[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
          end else begin
            fetch_addr_d = pc_q;
            state_d      = REQ;
`ifdef PC_FETCH_TIMEOUT_EN
            wcnt_d       = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DONE;
        end else begin
`ifdef PC_FETCH_TIMEOUT_EN
          // ready in the same cycle as the limit takes the branch above
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d == 8'(TIMEOUT)) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      epc_q         <= '0;
      ir_q          <= '0;
      fetch_addr_q  <= '0;
      mem_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      ir_q          <= ir_d;
      fetch_addr_q  <= fetch_addr_d;
      mem_rd_q      <= (state_d == REQ);
      busy_q        <= (state_d == REQ);
      instr_valid_q <= (state_d == DONE);
      addr_err_q    <= addr_err_d;
    end
  end

`ifdef PC_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = bus_err_d;
`endif

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = fetch_addr_q;
  assign pc_out      = pc_q;
  assign epc_out     = epc_q;
  assign ir_out      = ir_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed stimulus pushes expected events, a negedge monitor pops them.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset, pc_write, pc_write_cond, cond_true, epc_write, fetch_start, mem_ready;
  logic [31:0] pc_in, mem_rdata;
  logic        mem_rd, instr_valid, busy, addr_err, bus_err;
  logic [31:0] mem_addr, pc_out, epc_out, ir_out;

  int total = 0;
  int bad   = 0;

  localparam int K_INSTR = 1;
  localparam int K_AERR  = 2;
  localparam int K_BERR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  pc_fetch #(.RESET_PC(32'h0000_0100), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .cond_true(cond_true), .epc_write(epc_write),
    .fetch_start(fetch_start), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .pc_out(pc_out), .epc_out(epc_out),
    .ir_out(ir_out), .instr_valid(instr_valid), .busy(busy),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(kind), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_data", act, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid) sb_pop(K_INSTR, ir_out);
    if (addr_err)    sb_pop(K_AERR, 32'd0);
    if (bus_err)     sb_pop(K_BERR, 32'd0);
  end

  task automatic push(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0;
    epc_write = 1'b0; fetch_start = 1'b0; mem_ready = 1'b0;
    pc_in = '0; mem_rdata = '0;
    tick(); tick();

    // reset state
    check("rst_pc", pc_out, 32'h100);
    check("rst_epc", epc_out, 32'h0);
    check("rst_ir", ir_out, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_flags", {27'd0, mem_rd, instr_valid, busy, addr_err, bus_err}, 32'h0);
    reset = 1'b0;
    tick();

    // zero-wait fetch at 0x100
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f1_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd1);
    check("f1_addr", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'h8C22_0004;
    push(K_INSTR, 32'h8C22_0004);
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    check("f1_valid", {31'd0, instr_valid}, 32'd1);
    check("f1_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
    tick();
    check("f1_valid_pulse", {31'd0, instr_valid}, 32'd0);

    // pc write priority
    pc_write = 1'b1; pc_write_cond = 1'b1; cond_true = 1'b1; pc_in = 32'h200;
    tick();
    check("pc_uncond", pc_out, 32'h200);
    pc_write = 1'b0; cond_true = 1'b0; pc_in = 32'h300;
    tick();
    check("pc_cond_false", pc_out, 32'h200);
    cond_true = 1'b1;
    tick();
    check("pc_cond_true", pc_out, 32'h300);
    pc_write_cond = 1'b0; cond_true = 1'b0; pc_write = 1'b1; pc_in = 32'h200;
    tick();
    pc_write = 1'b0;
    check("pc_restore", pc_out, 32'h200);

    // fetch at 0x200 with 3 wait cycles, PC writes at accept and during REQ, extra fetch_start
    fetch_start = 1'b1; pc_write = 1'b1; pc_in = 32'h204;
    tick();
    fetch_start = 1'b0; pc_in = 32'h20C;
    check("f2_addr_accept", mem_addr, 32'h200);
    check("f2_pc_accept", pc_out, 32'h204);
    tick();
    pc_write = 1'b0; fetch_start = 1'b1;
    check("f2_addr_pcwr", mem_addr, 32'h200);
    check("f2_pc_req", pc_out, 32'h20C);
    tick();
    fetch_start = 1'b0;
    tick();
    check("f2_wait_busy", {30'd0, mem_rd, busy}, 32'd3);
    mem_ready = 1'b1; mem_rdata = 32'h0123_4567;
    push(K_INSTR, 32'h0123_4567);
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    check("f2_addr_hold", mem_addr, 32'h200);
    tick(); tick(); tick();
    check("f2_no_refetch", {30'd0, mem_rd, busy}, 32'd0);
    epc_write = 1'b1;
    tick();
    epc_write = 1'b0;
    check("epc", epc_out, 32'h200);

    // misaligned fetch
    pc_write = 1'b1; pc_in = 32'h202;
    tick();
    pc_write = 1'b0;
    check("pc_misaligned", pc_out, 32'h202);
    fetch_start = 1'b1;
    push(K_AERR, 32'd0);
    tick();
    fetch_start = 1'b0;
    check("aerr_pulse", {31'd0, addr_err}, 32'd1);
    check("aerr_no_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    check("aerr_clear", {31'd0, addr_err}, 32'd0);
    check("aerr_no_rd2", {31'd0, mem_rd}, 32'd0);
    check("aerr_ir", ir_out, 32'h0123_4567);

    // stalled fetch at 0x208
    pc_write = 1'b1; pc_in = 32'h208;
    tick();
    pc_write = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
    tick(); tick(); tick();
    check("tmo_req4", {30'd0, mem_rd, busy}, 32'd3);
    push(K_BERR, 32'd0);
    tick();
    check("tmo_berr", {31'd0, bus_err}, 32'd1);
    check("tmo_idle", {30'd0, mem_rd, busy}, 32'd0);
    check("tmo_ir", ir_out, 32'h0123_4567);
    tick();
    check("tmo_berr_pulse", {31'd0, bus_err}, 32'd0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
`else
    begin
      int busy_cycles = 0;
      for (int i = 0; i < 100; i++) begin
        if (busy && mem_rd) busy_cycles++;
        tick();
      end
      check("stall_busy_cycles", 32'(busy_cycles), 32'd100);
      check("stall_no_berr", {31'd0, bus_err}, 32'd0);
    end
`endif

    // reset during REQ aborts, even with mem_ready present
    check("abort_in_req", {31'd0, mem_rd}, 32'd1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    check("abort_rd", {31'd0, mem_rd}, 32'd0);
    check("abort_pc", pc_out, 32'h100);
    check("abort_valid", {31'd0, instr_valid}, 32'd0);
    check("abort_ir", ir_out, 32'h0);
    tick(); tick(); tick();
    check("abort_idle", {30'd0, mem_rd, busy}, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
